// File: rtl/polylut_flow_pkg.sv
// Shared defaults, helper function and result type for the PolyLUT flow controller.
// Optional perf counters are enabled by defining POLYLUT_FLOW_PERF_CNT_EN.
package polylut_flow_pkg;

  localparam int NUM_STAGES_DEF = 5;
  localparam int OUT_W_DEF      = 25;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CNT_W_DEF      = 32;

  // Ceiling log2 usable in parameter expressions; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef logic [OUT_W_DEF-1:0] res_t;

endpackage

// File: rtl/polylut_res_fifo.sv
// First-word-fall-through result FIFO with occupancy count and synchronous flush.
// Head data is valid whenever o_count is non-zero.
module polylut_res_fifo
  import polylut_flow_pkg::*;
#(
  parameter int W     = OUT_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;

  assign w_pop = i_pop & (r_count != '0);

  // Pointers wrap naturally; push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(i_push && !w_pop && !i_flush && (r_count == FULL)));

endmodule

// File: rtl/polylut_flow_ctrl.sv
// Credit-based valid/ready controller for the 5-stage PolyLUT pipeline with result FIFO.
// Define POLYLUT_FLOW_PERF_CNT_EN to add saturating accepted/stall/retired counters.
module polylut_flow_ctrl
  import polylut_flow_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_STAGES-1:0] stage_en,
  input  logic [OUT_W-1:0]      res_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  busy
`ifdef POLYLUT_FLOW_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      perf_accepted,
  output logic [CNT_W-1:0]      perf_stall,
  output logic [CNT_W-1:0]      perf_retired
`endif
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int IW = clog2(NUM_STAGES + 1);
  localparam logic [AW+1:0] DEPTH_L = (AW+2)'(FIFO_DEPTH);

  if (FIFO_DEPTH < NUM_STAGES + 1 || NUM_STAGES < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("polylut_flow_ctrl: unsupported parameter combination");
  end

  logic [NUM_STAGES-1:0] r_vld;
  logic [IW-1:0]         r_inflight;
  logic [AW:0]           w_count;
  logic [AW+1:0]         w_used;
  logic                  w_in_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_out_valid;

  // Handshake: a transfer happens on a clock edge where valid & ready are both high;
  // in_ready depends only on registered credit state and flush, never on out_ready.
  assign w_used    = (AW+2)'(w_count) + (AW+2)'(r_inflight);
  assign in_ready  = rst & ~flush & (w_used < DEPTH_L);
  assign w_in_fire = in_valid & in_ready;

  assign w_push      = r_vld[NUM_STAGES-1] & ~flush;
  assign w_out_valid = (w_count != '0);
  assign w_pop       = w_out_valid & out_ready & ~flush;

  assign stage_en  = {r_vld[NUM_STAGES-2:0], w_in_fire};
  assign out_valid = w_out_valid;
  assign busy      = (r_inflight != '0) | w_out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld      <= '0;
      r_inflight <= '0;
    end else if (flush) begin
      r_vld      <= '0;
      r_inflight <= '0;
    end else begin
      r_vld      <= {r_vld[NUM_STAGES-2:0], w_in_fire};
      r_inflight <= r_inflight + IW'(w_in_fire) - IW'(r_vld[NUM_STAGES-1]);
    end
  end

  polylut_res_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (res_data),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_count (w_count)
  );

`ifdef POLYLUT_FLOW_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_acc;
  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_ret;

  // Counters survive flush and stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_acc   <= '0;
      r_perf_stall <= '0;
      r_perf_ret   <= '0;
    end else begin
      if (w_in_fire && (r_perf_acc != '1)) r_perf_acc <= r_perf_acc + CNT_W'(1);
      if (in_valid && !in_ready && !flush && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + CNT_W'(1);
      if (w_pop && (r_perf_ret != '1)) r_perf_ret <= r_perf_ret + CNT_W'(1);
    end
  end

  assign perf_accepted = r_perf_acc;
  assign perf_stall    = r_perf_stall;
  assign perf_retired  = r_perf_ret;
`endif

endmodule
